task_output_pingpong_buffer: RTL and testbench

- Parametrised packet output stage for task blocks. Collects task result words into one of two internal banks, then streams each complete packet to the manager with last flag and packet size.
- Ping-pong banking lets the task load packet N+1 while packet N is being sent.
- Packet length is run-time configurable per packet, not fixed.
- Sits between a task core (write side) and the task manager (read side).

---
 rtl/task_output_pingpong_buffer.sv | 179 +++++++++++++++++
 tb/tb_task_output_pingpong_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_output_pingpong_buffer.sv
// Two-bank packet buffer between a task core and the task manager: one bank loads while the other streams out.
// First word appears 2 cycles after a bank completes; FWFT output holds while i_tmanager_ready is low; o_in_ready drops when both banks hold packets.
module task_output_pingpong_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int SIZE_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SIZE_W-1:0] i_cfg_pkt_size,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_in_ready,
    input  logic              i_flush,
    input  logic              i_tmanager_ready,
    output logic              o_tanswer_ready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tanswer_data_last,
    output logic [SIZE_W-1:0] o_packet_size_in_bytes,
    output logic              o_busy,
    output logic              o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(DEPTH);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILL,
        B_READY,
        B_SEND
    } bank_st_e;

    bank_st_e [1:0]          st_q, st_d;
    logic [1:0][SIZE_W-1:0]  wr_idx_q, wr_idx_d;
    logic [1:0][SIZE_W-1:0]  size_q, size_d;
    logic                    wb_q, wb_d;
    logic                    rb_q, rb_d;
    logic [SIZE_W-1:0]       rd_idx_q, rd_idx_d;
    logic                    s1_vld_q, s1_vld_d;
    logic                    s1_last_q, s1_last_d;
    logic [DATA_W-1:0]       s1_dat_q;
    logic                    s2_vld_q, s2_vld_d;
    logic                    s2_last_q, s2_last_d;
    logic [DATA_W-1:0]       tdata_q, tdata_d;

    logic [DATA_W-1:0]       mem [2*DEPTH];

    logic              in_ready;
    logic              wr_acc;
    logic [SIZE_W-1:0] cfg_eff;
    logic [SIZE_W-1:0] wr_size;
    logic              start;
    logic              rd_active;
    logic              pop;
    logic              s1_adv;
    logic              issue;
    logic              issue_last;
    logic              pkt_done;

    always_comb begin
        in_ready   = (st_q[wb_q] == B_EMPTY) || (st_q[wb_q] == B_FILL);
        wr_acc     = i_data_valid && in_ready && !i_flush;
        cfg_eff    = ((i_cfg_pkt_size == '0) || (i_cfg_pkt_size > DEPTH_S)) ? DEPTH_S : i_cfg_pkt_size;
        wr_size    = (st_q[wb_q] == B_EMPTY) ? cfg_eff : size_q[wb_q];
        // The first RAM read is issued while the bank is still READY so data lands 2 cycles later.
        start      = (st_q[rb_q] == B_READY);
        rd_active  = start || (st_q[rb_q] == B_SEND);
        pop        = s2_vld_q && i_tmanager_ready;
        s1_adv     = s1_vld_q && (!s2_vld_q || pop);
        issue      = rd_active && (rd_idx_q < size_q[rb_q]) && (!s1_vld_q || s1_adv);
        issue_last = (rd_idx_q == size_q[rb_q] - SIZE_W'(1));
        pkt_done   = pop && s2_last_q;
    end

    always_comb begin
        st_d      = st_q;
        wr_idx_d  = wr_idx_q;
        size_d    = size_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        rd_idx_d  = rd_idx_q;
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s2_vld_d  = s2_vld_q;
        s2_last_d = s2_last_q;
        tdata_d   = tdata_q;

        // Write side only ever touches a bank in EMPTY/FILL, read side only READY/SEND.
        if (i_flush && (st_q[wb_q] == B_FILL)) begin
            st_d[wb_q]     = B_EMPTY;
            wr_idx_d[wb_q] = '0;
        end else if (wr_acc) begin
            size_d[wb_q] = wr_size;
            if (wr_idx_q[wb_q] + SIZE_W'(1) == wr_size) begin
                st_d[wb_q]     = B_READY;
                wr_idx_d[wb_q] = '0;
                wb_d           = !wb_q;
            end else begin
                st_d[wb_q]     = B_FILL;
                wr_idx_d[wb_q] = wr_idx_q[wb_q] + SIZE_W'(1);
            end
        end

        if (start) begin
            st_d[rb_q] = B_SEND;
        end

        if (issue) begin
            rd_idx_d  = rd_idx_q + SIZE_W'(1);
            s1_vld_d  = 1'b1;
            s1_last_d = issue_last;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end

        if (s1_adv) begin
            s2_vld_d  = 1'b1;
            s2_last_d = s1_last_q;
            tdata_d   = s1_dat_q;
        end else if (pop) begin
            s2_vld_d = 1'b0;
        end

        if (pkt_done) begin
            st_d[rb_q] = B_EMPTY;
            rb_d       = !rb_q;
            rd_idx_d   = '0;
            s2_last_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q      <= {B_EMPTY, B_EMPTY};
            wr_idx_q  <= '0;
            size_q    <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            rd_idx_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            tdata_q   <= '0;
        end else begin
            st_q      <= st_d;
            wr_idx_q  <= wr_idx_d;
            size_q    <= size_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            rd_idx_q  <= rd_idx_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            tdata_q   <= tdata_d;
        end
    end

    // Bank storage: bank select is the top address bit; read data register has an enable.
    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[{wb_q, wr_idx_q[wb_q][AW-1:0]}] <= i_data;
        end
        if (issue) begin
            s1_dat_q <= mem[{rb_q, rd_idx_q[AW-1:0]}];
        end
    end

    assign o_in_ready             = in_ready;
    assign o_full                 = !in_ready;
    assign o_tanswer_ready        = s2_vld_q;
    assign o_tdata                = tdata_q;
    assign o_tanswer_data_last    = s2_vld_q && s2_last_q;
    assign o_packet_size_in_bytes = s2_vld_q ? size_q[rb_q] : '0;
    assign o_busy                 = (st_q[rb_q] == B_SEND);

endmodule

// File: tb/tb_task_output_pingpong_buffer.sv
// Bench for task_output_pingpong_buffer: a queue-based packet model predicts every output
// cycle by cycle from the accepted writes; the monitor compares on the falling edge.
module tb_task_output_pingpong_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int SIZE_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SIZE_W-1:0] cfg = '0;
    logic [DATA_W-1:0] din = '0;
    logic              dvld = 1'b0;
    logic              flush = 1'b0;
    logic              mrdy = 1'b0;
    logic              in_rdy, tv, tlast, busy, full;
    logic [DATA_W-1:0] tdata;
    logic [SIZE_W-1:0] psize;

    task_output_pingpong_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .SIZE_W(SIZE_W)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_cfg_pkt_size        (cfg),
        .i_data                (din),
        .i_data_valid          (dvld),
        .o_in_ready            (in_rdy),
        .i_flush               (flush),
        .i_tmanager_ready      (mrdy),
        .o_tanswer_ready       (tv),
        .o_tdata               (tdata),
        .o_tanswer_data_last   (tlast),
        .o_packet_size_in_bytes(psize),
        .o_busy                (busy),
        .o_full                (full)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DATA_W-1:0] exp_words[$];
    int                pkt_sizes[$];
    int                pkt_cyc[$];
    logic [DATA_W-1:0] fill_q[$];
    int                fill_size = 0;
    bit                filling = 0;
    int                wpos = 0;
    int                cyc = 0;
    int                last_done = -100;
    int                sent_words = 0;
    bit                started = 0;
    bit                chk_zero = 0;
    int                total = 0;
    int                bad = 0;

    function automatic int clampsz(int c);
        return (c == 0 || c > DEPTH) ? DEPTH : c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit m_rdy, m_tv, m_busy, m_last;
        int hsz, avail;
        m_rdy  = pkt_sizes.size() < 2;
        m_tv   = 0;
        m_busy = 0;
        m_last = 0;
        hsz    = 0;
        if (pkt_sizes.size() > 0) begin
            avail  = ((pkt_cyc[0] > last_done) ? pkt_cyc[0] : last_done) + 2;
            hsz    = pkt_sizes[0];
            m_tv   = cyc >= avail;
            m_busy = cyc >= avail - 1;
            m_last = m_tv && (wpos == hsz - 1);
        end
        if (started) begin
            chk("in_ready", 32'(in_rdy), 32'(m_rdy));
            chk("full", 32'(full), 32'(!m_rdy));
            chk("tanswer_ready", 32'(tv), 32'(m_tv));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("last", 32'(tlast), 32'(m_last));
            chk("pkt_size", 32'(psize), m_tv ? 32'(hsz) : 32'd0);
            if (m_tv) chk("tdata", 32'(tdata), 32'(exp_words[0]));
            if (chk_zero) chk("tdata_reset", 32'(tdata), 32'd0);
        end
        chk_zero = 0;
        if (rst) begin
            exp_words.delete();
            pkt_sizes.delete();
            pkt_cyc.delete();
            fill_q.delete();
            filling   = 0;
            wpos      = 0;
            last_done = -100;
            started   = 1;
            chk_zero  = 1;
        end else begin
            if (m_tv && mrdy) begin
                void'(exp_words.pop_front());
                wpos++;
                sent_words++;
                if (wpos == hsz) begin
                    void'(pkt_sizes.pop_front());
                    void'(pkt_cyc.pop_front());
                    wpos      = 0;
                    last_done = cyc + 1;
                end
            end
            if (flush) begin
                fill_q.delete();
                filling = 0;
            end else if (dvld && m_rdy) begin
                if (!filling) begin
                    filling   = 1;
                    fill_size = clampsz(int'(cfg));
                end
                fill_q.push_back(din);
                if (fill_q.size() == fill_size) begin
                    foreach (fill_q[k]) exp_words.push_back(fill_q[k]);
                    pkt_sizes.push_back(fill_size);
                    pkt_cyc.push_back(cyc + 1);
                    fill_q.delete();
                    filling = 0;
                end
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        din  = d;
        dvld = 1'b1;
        step();
        dvld = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        dvld = 1'b0;
        while (pkt_sizes.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        if (pkt_sizes.size() != 0) chk("drain_timeout", 32'(pkt_sizes.size()), 32'd0);
        step();
    endtask

    initial begin
        int base, n;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 16-word packet, manager always ready
        mrdy = 1'b1;
        cfg  = 12'd16;
        for (int i = 0; i < 16; i++) wr(8'(i));
        drain(100);

        // two 8-word packets with manager stalled, 17th write refused
        mrdy = 1'b0;
        cfg  = 12'd8;
        for (int i = 0; i < 17; i++) wr(8'(8'h20 + i));
        repeat (5) step();
        mrdy = 1'b1;
        drain(100);

        // stalls with a 1,0,0,1 ready pattern
        cfg = 12'd5;
        for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
        for (int i = 0; i < 60 && pkt_sizes.size() != 0; i++) begin
            mrdy = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        mrdy = 1'b1;
        drain(20);

        // clamping: size 0 and 2000 both give DEPTH words; size changes mid-packet are ignored
        cfg = 12'd0;
        wr(8'h11);
        cfg = 12'd3;
        for (int i = 1; i < DEPTH; i++) wr(8'($urandom));
        drain(1200);
        cfg = 12'd2000;
        for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
        drain(1200);
        cfg = 12'd1;
        wr(8'h5A);
        drain(20);

        // flush a partial packet, then a flush (with a dropped write) during a send
        cfg = 12'd8;
        for (int i = 0; i < 3; i++) wr(8'(8'h90 + i));
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(8'hA0 + i));
        step();
        step();
        flush = 1'b1;
        din   = 8'hEE;
        dvld  = 1'b1;
        step();
        flush = 1'b0;
        dvld  = 1'b0;
        drain(50);

        // reset in the middle of a 10-word send
        cfg = 12'd10;
        for (int i = 0; i < 10; i++) wr(8'(8'h60 + i));
        base = sent_words;
        n = 0;
        while (sent_words < base + 4 && n < 50) begin
            step();
            n++;
        end
        if (sent_words < base + 4) chk("midsend_timeout", 32'(sent_words - base), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        cfg = 12'd6;
        for (int i = 0; i < 6; i++) wr(8'(8'h70 + i));
        drain(50);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            dvld  = ($urandom % 10) < 7;
            din   = 8'($urandom);
            cfg   = (($urandom % 200) == 0) ? 12'd0 : 12'($urandom_range(1, 20));
            mrdy  = ($urandom % 10) < 6;
            flush = ($urandom % 50) == 0;
            step();
        end
        dvld  = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        mrdy  = 1'b1;
        drain(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
